// File: rtl/equiv_pkg.sv
// equiv_pkg: shared types and default constants for the equivalence miter.
// Holds the FSM state enum, parameter defaults and a small max helper.
package equiv_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FAILED = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 91;
    localparam int DEF_SKEW   = 0;
    localparam int DEF_WARMUP = 2;
    localparam int DEF_CNT_W  = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/equiv_delay_line.sv
// equiv_delay_line: DEPTH-stage enable-gated register delay, DEPTH=0 is a wire.
// Ports: clk, rst_n (async active-low), en (shift enable), d (in), q (delayed out).
module equiv_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, en};
        assign q = d;
    end else begin : g_regs
        logic [WIDTH-1:0] stg_q [DEPTH];
        logic [WIDTH-1:0] stg_d [DEPTH];

        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_d[i] = stg_q[i];
            end
            if (en) begin
                stg_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    stg_d[i] = stg_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stg_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    stg_q[i] <= stg_d[i];
                end
            end
        end

        assign q = stg_q[DEPTH-1];
    end

endmodule

// File: rtl/equiv_miter_monitor.sv
// equiv_miter_monitor: compares y_a (delayed SKEW cycles) against y_b after a
// warm-up, flags mismatches, counts them and captures the first difference.
// Ports: clk, rst_n (async active-low), en (freeze when low), clear (sync restart),
//   y_a/y_b (compared vectors), mismatch (pulse), fail (sticky),
//   mismatch_cnt, first_cycle, first_diff (captures), state (FSM encoding).
// Optional: define EQUIV_MITER_ASSERT_EN to compile an equality assertion.
module equiv_miter_monitor
    import equiv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SKEW   = DEF_SKEW,
    parameter int WARMUP = DEF_WARMUP,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] y_a,
    input  logic [WIDTH-1:0] y_b,
    output logic             mismatch,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_cycle,
    output logic [WIDTH-1:0] first_diff,
    output logic [1:0]       state
);

    // The delay line must be full before comparing, so warm-up covers SKEW too.
    localparam int WARM_LEN  = max_int(WARMUP, SKEW);
    localparam int WARM_LAST = (WARM_LEN > 0) ? WARM_LEN - 1 : 0;
    localparam int WC_W      = (WARM_LAST > 0) ? $clog2(WARM_LAST + 1) : 1;

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fcyc_q, fcyc_d;
    logic [WIDTH-1:0] fdiff_q, fdiff_d;
    logic             mm_q, mm_d;
    logic             fail_q, fail_d;

    logic [WIDTH-1:0] ya_dly;
    logic [WIDTH-1:0] diff;
    logic             cmp;
    logic             hit;

    equiv_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (SKEW)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (y_a),
        .q     (ya_dly)
    );

    assign diff = ya_dly ^ y_b;
    // Gating by state keeps X on the inputs during warm-up from reaching hit.
    assign cmp  = en && !clear && (state_q != ST_WARMUP);
    assign hit  = cmp && (diff != '0);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        fcyc_d  = fcyc_q;
        fdiff_d = fdiff_q;
        fail_d  = fail_q;
        mm_d    = 1'b0;
        if (clear) begin
            state_d = ST_WARMUP;
            wcnt_d  = '0;
            cyc_d   = '0;
            cnt_d   = '0;
            fcyc_d  = '0;
            fdiff_d = '0;
            fail_d  = 1'b0;
        end else if (en) begin
            unique case (state_q)
                ST_WARMUP: begin
                    if (wcnt_q == WC_W'(WARM_LAST)) begin
                        state_d = ST_ARMED;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                ST_ARMED, ST_FAILED: begin
                    if (cyc_q != '1) begin
                        cyc_d = cyc_q + 1'b1;
                    end
                    if (hit) begin
                        mm_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (state_q == ST_ARMED) begin
                            fcyc_d  = cyc_q;
                            fdiff_d = diff;
                            fail_d  = 1'b1;
                            state_d = ST_FAILED;
                        end
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WARMUP;
            wcnt_q  <= '0;
            cyc_q   <= '0;
            cnt_q   <= '0;
            fcyc_q  <= '0;
            fdiff_q <= '0;
            fail_q  <= 1'b0;
            mm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            fcyc_q  <= fcyc_d;
            fdiff_q <= fdiff_d;
            fail_q  <= fail_d;
            mm_q    <= mm_d;
        end
    end

    assign mismatch     = mm_q;
    assign fail         = fail_q;
    assign mismatch_cnt = cnt_q;
    assign first_cycle  = fcyc_q;
    assign first_diff   = fdiff_q;
    assign state        = state_q;

`ifdef EQUIV_MITER_ASSERT_EN
    always @(posedge clk) begin
        if (rst_n && en && (state_q != ST_WARMUP)) begin
            assert (ya_dly == y_b)
            else $error("equiv_miter_monitor: outputs diverge, diff=%h", diff);
        end
    end
`endif

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// tb_equiv_miter_monitor: two monitor instances (SKEW=0/CNT_W=16 and
// SKEW=3/CNT_W=4) on shared stimulus, checked against a reference model.
module tb_equiv_miter_monitor;

    localparam int W = 91;
    typedef logic [W-1:0] vec_t;
    typedef logic [127:0] wide_t;

    logic clk = 1'b0;
    logic rst_n, en, clear;
    vec_t y_a, y_b;

    logic       mm0, mm1, fl0, fl1;
    logic [1:0] st0, st1;
    logic [15:0] cnt0, fc0;
    logic [3:0]  cnt1, fc1;
    vec_t        fd0, fd1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    equiv_miter_monitor #(
        .WIDTH(W), .SKEW(0), .WARMUP(2), .CNT_W(16)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .y_a(y_a), .y_b(y_b), .mismatch(mm0), .fail(fl0),
        .mismatch_cnt(cnt0), .first_cycle(fc0),
        .first_diff(fd0), .state(st0)
    );

    equiv_miter_monitor #(
        .WIDTH(W), .SKEW(3), .WARMUP(2), .CNT_W(4)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .y_a(y_a), .y_b(y_b), .mismatch(mm1), .fail(fl1),
        .mismatch_cnt(cnt1), .first_cycle(fc1),
        .first_diff(fd1), .state(st1)
    );

    // Reference model: history of y_a samples taken on enabled cycles,
    // plus per-instance phase, counters and first-failure record.
    vec_t hist[$];
    int   skew_of[2] = '{0, 3};
    int   cw_of[2]   = '{16, 4};
    int   m_wc[2], m_cyc[2], m_cnt[2], m_fcyc[2];
    bit   m_arm[2], m_fail[2], m_mm[2];
    vec_t m_fdiff[2];

    function automatic vec_t rand_w();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic vec_t dly(int s);
        if (s == 0) return y_a;
        return hist[hist.size() - s];
    endfunction

    function automatic int m_state(int i);
        if (!m_arm[i]) return 0;
        return m_fail[i] ? 2 : 1;
    endfunction

    task automatic model_zero(int i);
        m_wc[i] = 0; m_cyc[i] = 0; m_cnt[i] = 0; m_fcyc[i] = 0;
        m_arm[i] = 0; m_fail[i] = 0; m_mm[i] = 0; m_fdiff[i] = '0;
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 8; k++) hist.push_back('0);
        for (int i = 0; i < 2; i++) model_zero(i);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int   lim;
            int   wl;
            vec_t d;
            lim = (1 << cw_of[i]) - 1;
            wl  = (skew_of[i] > 2) ? skew_of[i] : 2;
            d   = dly(skew_of[i]) ^ y_b;
            m_mm[i] = 0;
            if (clear) begin
                model_zero(i);
            end else if (en) begin
                if (!m_arm[i]) begin
                    m_wc[i]++;
                    if (m_wc[i] >= wl) m_arm[i] = 1;
                end else begin
                    if (d != '0) begin
                        m_mm[i] = 1;
                        if (m_cnt[i] < lim) m_cnt[i]++;
                        if (!m_fail[i]) begin
                            m_fail[i]  = 1;
                            m_fcyc[i]  = m_cyc[i];
                            m_fdiff[i] = d;
                        end
                    end
                    if (m_cyc[i] < lim) m_cyc[i]++;
                end
            end
        end
        if (en) hist.push_back(y_a);
    endtask

    task automatic chk(input string tag, input wide_t act, input wide_t exp);
        n_checks++;
        assert (act === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all();
        chk("d0.mismatch", 128'(mm0), 128'(m_mm[0]));
        chk("d0.fail", 128'(fl0), 128'(m_fail[0]));
        chk("d0.state", 128'(st0), 128'(m_state(0)));
        chk("d0.cnt", 128'(cnt0), 128'(m_cnt[0]));
        chk("d0.first_cycle", 128'(fc0), 128'(m_fcyc[0]));
        chk("d0.first_diff", 128'(fd0), 128'(m_fdiff[0]));
        chk("d1.mismatch", 128'(mm1), 128'(m_mm[1]));
        chk("d1.fail", 128'(fl1), 128'(m_fail[1]));
        chk("d1.state", 128'(st1), 128'(m_state(1)));
        chk("d1.cnt", 128'(cnt1), 128'(m_cnt[1]));
        chk("d1.first_cycle", 128'(fc1), 128'(m_fcyc[1]));
        chk("d1.first_diff", 128'(fd1), 128'(m_fdiff[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        vec_t v;
        vec_t b5;
        vec_t b7;
        b5 = '0; b5[5] = 1'b1;
        b7 = '0; b7[7] = 1'b1;

        // reset state
        rst_n = 1'b1; en = 1'b0; clear = 1'b0;
        y_a = '0; y_b = '0;
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        chk("rst.state", 128'(st0), 128'd0);
        chk("rst.fail", 128'(fl0), 128'd0);
        chk("rst.mismatch", 128'(mm1), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // test 1: identical random outputs
        en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            v = rand_w(); y_a = v; y_b = v;
            tick();
            if (i == 0) chk("t1.warm_c1", 128'(st0), 128'd0);
            if (i == 1) chk("t1.armed_c2", 128'(st0), 128'd1);
        end
        chk("t1.fail", 128'(fl0), 128'd0);
        chk("t1.cnt", 128'(cnt0), 128'd0);
        chk("t1.state", 128'(st0), 128'd1);

        // test 2: skew alignment, then unaligned change
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 60; i++) begin
            y_a = rand_w(); y_b = dly(3);
            tick();
        end
        chk("t2.aligned_fail", 128'(fl1), 128'd0);
        chk("t2.aligned_cnt", 128'(cnt1), 128'd0);
        chk("t2.aligned_state", 128'(st1), 128'd1);
        y_a = rand_w(); y_b = y_a;
        tick();
        chk("t2.mm_first", 128'(mm1), 128'd1);
        chk("t2.state", 128'(st1), 128'd2);
        chk("t2.fcyc_sat", 128'(fc1), 128'd15);

        // test 3: single-bit flips at armed cycles 10 and 20
        clear = 1'b1; tick(); clear = 1'b0;
        v = rand_w(); y_a = v; y_b = v;
        tick(); tick();
        for (int k = 0; k < 30; k++) begin
            y_b = v;
            if (k == 10) y_b = v ^ b5;
            if (k == 20) y_b = v ^ b7;
            tick();
            if (k == 10) chk("t3.pulse", 128'(mm0), 128'd1);
            if (k == 11) chk("t3.pulse_end", 128'(mm0), 128'd0);
        end
        chk("t3.first_cycle", 128'(fc0), 128'd10);
        chk("t3.first_diff", 128'(fd0), 128'(b5));
        chk("t3.cnt", 128'(cnt0), 128'd2);
        chk("t3.fail", 128'(fl0), 128'd1);
        chk("t3.state", 128'(st0), 128'd2);

        // test 4: constant difference, counter saturation
        clear = 1'b1; tick(); clear = 1'b0;
        y_b = v ^ 91'd1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 30) chk("t4.sat_hold", 128'(cnt1), 128'd15);
        end
        chk("t4.cnt_sat", 128'(cnt1), 128'd15);
        chk("t4.cnt_wide", 128'(cnt0), 128'd38);

        // test 5: clear beats a same-cycle mismatch, then en low
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t5.cnt", 128'(cnt0), 128'd0);
        chk("t5.fail", 128'(fl0), 128'd0);
        chk("t5.state", 128'(st0), 128'd0);
        chk("t5.mm", 128'(mm0), 128'd0);
        chk("t5.fcyc", 128'(fc0), 128'd0);
        chk("t5.cnt1", 128'(cnt1), 128'd0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            y_a = rand_w(); y_b = rand_w();
            tick();
            chk("t5.hold_state", 128'(st0), 128'd0);
            chk("t5.hold_mm", 128'(mm0), 128'd0);
        end
        en = 1'b1; y_a = v; y_b = v;
        tick();
        chk("t5.warm_kept", 128'(st0), 128'd0);
        tick();
        chk("t5.armed", 128'(st0), 128'd1);

        // test 6: reach FAILED, freeze, then async reset pulse
        y_b = v ^ b7;
        tick(); tick(); tick();
        chk("t6.failed", 128'(st0), 128'd2);
        chk("t6.cnt", 128'(cnt0), 128'd3);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.frz_cnt", 128'(cnt0), 128'd3);
            chk("t6.frz_mm", 128'(mm0), 128'd0);
        end
        en = 1'b1; y_b = v;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6.rst_state", 128'(st0), 128'd0);
        chk("t6.rst_cnt", 128'(cnt0), 128'd0);
        chk("t6.rst_fdiff", 128'(fd0), 128'd0);
        chk("t6.rst_fail1", 128'(fl1), 128'd0);
        #1 rst_n = 1'b1;
        y_b = ~v;
        tick();
        chk("t6.ign_mm", 128'(mm0), 128'd0);
        y_b = 'x;
        tick();
        chk("t6.ign_x_mm", 128'(mm0), 128'd0);
        chk("t6.ign_fail", 128'(fl0), 128'd0);
        y_b = v;
        for (int i = 0; i < 4; i++) tick();
        chk("t6.end_state0", 128'(st0), 128'd1);
        chk("t6.end_state1", 128'(st1), 128'd1);
        chk("t6.end_fail1", 128'(fl1), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/equiv_miter_monitor.md
EQUIV_MITER_MONITOR -- requirements
Module: equiv_miter_monitor

Interface
REQ-001 Parameter WIDTH, default 91, bit width of each compared output vector.
REQ-002 Parameter SKEW, default 0, range 0..7, cycles of delay applied to y_a before comparison, to align a pipelined implementation.
REQ-003 Parameter WARMUP, default 2, cycles ignored after reset or clear.
REQ-004 Parameter CNT_W, default 16, width of the mismatch and cycle counters.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  compare enable; low freezes all counters and state.
REQ-008 clear  input  1  synchronous restart to WARMUP, clearing counters and captures.
REQ-009 y_a  input  WIDTH  output of implementation A.
REQ-010 y_b  input  WIDTH  output of implementation B.
REQ-011 mismatch  output  1  registered one-cycle pulse per detected difference.
REQ-012 fail  output  1  sticky, set on first mismatch.
REQ-013 mismatch_cnt  output  CNT_W  number of mismatches, saturating.
REQ-014 first_cycle  output  CNT_W  value of the cycle counter at the first mismatch.
REQ-015 first_diff  output  WIDTH  y_a_delayed XOR y_b at the first mismatch.
REQ-016 state  output  2  current FSM state encoding.

Function
REQ-017 The FSM SHALL have three states: WARMUP=0, ARMED=1, FAILED=2.
REQ-018 The effective warm-up length SHALL be max(WARMUP, SKEW) cycles with en high; WARMUP SHALL then move to ARMED.
REQ-019 The cycle counter SHALL increment on every en-high cycle outside WARMUP and SHALL saturate at all-ones.
REQ-020 y_a SHALL pass through a SKEW-deep register delay line; SKEW=0 SHALL be a pure wire.
REQ-021 In ARMED or FAILED with en high, the block SHALL compare delayed y_a with y_b; on inequality it SHALL assert mismatch on the next cycle.
REQ-022 The first mismatch SHALL capture first_cycle and first_diff, set fail, and move to FAILED; later mismatches SHALL NOT overwrite the captures.
REQ-023 mismatch_cnt SHALL increment once per mismatch and hold at 2^CNT_W-1.
REQ-024 FAILED SHALL compare and count, and SHALL leave only on clear or reset.
REQ-025 With en low, mismatch SHALL be 0 and state, counters and the delay line SHALL hold.
REQ-026 When clear and a mismatch occur in the same cycle, clear SHALL win: no count and no capture.
REQ-027 No comparison SHALL occur in WARMUP, including X/undefined differences.

Reset
REQ-028 On rst_n low, state SHALL be WARMUP, mismatch=0, fail=0, and all counters, captures and delay-line stages SHALL be 0, asynchronously.
REQ-029 Deassertion of rst_n mid-operation SHALL restart the full warm-up.

Configuration
REQ-030 With EQUIV_MITER_ASSERT_EN defined, the block SHALL contain an immediate assertion, at each clock, that delayed y_a equals y_b whenever en is high and state is not WARMUP.
REQ-031 Without EQUIV_MITER_ASSERT_EN, no assertion SHALL be compiled and all port behaviour SHALL be identical.

Structure
REQ-032 Package equiv_pkg SHALL hold the state enum and the default constants for WIDTH, SKEW, WARMUP and CNT_W.
REQ-033 The delay line SHALL be a sub-module, equiv_delay_line, with parameters WIDTH and DEPTH, ports clk, rst_n, en, d and q.

Verification
REQ-034 Test 1: reset, then drive y_a=y_b=random for 100 cycles -> fail=0, mismatch_cnt=0, state=ARMED after cycle 2.
REQ-035 Test 2: SKEW=3, drive y_b = y_a delayed by 3 cycles -> no mismatch; with y_b = y_a undelayed and changing -> mismatch at the first armed change.
REQ-036 Test 3: flip bit 5 of y_b at armed cycle 10 and bit 7 at cycle 20 -> first_cycle=10, first_diff=0x20, mismatch_cnt=2, fail=1, state=FAILED.
REQ-037 Test 4: CNT_W=4, hold a constant difference for 40 cycles -> mismatch_cnt=15 and stays at 15.
REQ-038 Test 5: assert clear in the same cycle as a mismatch -> counters 0, fail=0, state=WARMUP; hold en low for 5 cycles -> all outputs unchanged.
REQ-039 Test 6: pulse rst_n low in FAILED, asynchronous to clk -> outputs 0 immediately, and a mismatch during the following 2 cycles is ignored.
